hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller_pkg.sv | 30 +++
 rtl/hazard_controller_detect.sv | 37 +++
 rtl/hazard_controller.sv | 144 ++++++++++++++
 tb/tb_hazard_controller.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: register index width,
// default memory timeout, controller state encoding and the register-match rule.
`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef MEM_TIMEOUT_DEFAULT
`define MEM_TIMEOUT_DEFAULT 16
`endif

package hazard_controller_pkg;

    localparam int unsigned RegIdxWidth       = `REG_IDX_WIDTH;
    localparam int unsigned MemTimeoutDefault = `MEM_TIMEOUT_DEFAULT;

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StMwait = 2'b01,
        StFault = 2'b10
    } ctrl_state_e;

    // x0 is hard-wired to zero, so a write to it can never feed a consumer.
    function automatic logic reg_match(input logic [RegIdxWidth-1:0] src,
                                       input logic [RegIdxWidth-1:0] dst);
        return (dst != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_controller_detect.sv
// Combinational data-hazard detection between the ID stage and the EX/MEM stages.
module hazard_detect
    import hazard_controller_pkg::*;
(
    input  logic [RegIdxWidth-1:0] readAddr1_ID,
    input  logic [RegIdxWidth-1:0] readAddr2_ID,
    input  logic                   useRs1_ID,
    input  logic                   useRs2_ID,
    input  logic                   branch_ID,
    input  logic                   regWrite_EX,
    input  logic                   memRead_EX,
    input  logic [RegIdxWidth-1:0] writeAddr_EX,
    input  logic                   memRead_MEM,
    input  logic [RegIdxWidth-1:0] writeAddr_MEM,
    output logic                   load_use,
    output logic                   data_stall
);

    logic hit_ex;
    logic hit_mem;
    logic branch_alu;
    logic branch_load;

    assign hit_ex  = (useRs1_ID && reg_match(readAddr1_ID, writeAddr_EX)) ||
                     (useRs2_ID && reg_match(readAddr2_ID, writeAddr_EX));
    assign hit_mem = (useRs1_ID && reg_match(readAddr1_ID, writeAddr_MEM)) ||
                     (useRs2_ID && reg_match(readAddr2_ID, writeAddr_MEM));

    assign load_use = memRead_EX && hit_ex;

    // An ALU result one stage ahead reaches the branch comparator via MEM->ID next cycle.
    assign branch_alu  = branch_ID && regWrite_EX && !memRead_EX && hit_ex;
    assign branch_load = branch_ID && ((memRead_EX && hit_ex) || (memRead_MEM && hit_mem));

    assign data_stall = load_use || branch_alu || branch_load;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: data-hazard stalls, taken-branch flush, data-memory
// wait handling with a timeout fault, and a stall-cycle performance counter.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MemTimeoutDefault,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [RegIdxWidth-1:0] readAddr1_ID,
    input  logic [RegIdxWidth-1:0] readAddr2_ID,
    input  logic                   useRs1_ID,
    input  logic                   useRs2_ID,
    input  logic                   branch_ID,
    input  logic                   branchTaken_ID,
    input  logic                   regWrite_EX,
    input  logic                   memRead_EX,
    input  logic [RegIdxWidth-1:0] writeAddr_EX,
    input  logic                   regWrite_MEM,
    input  logic                   memRead_MEM,
    input  logic [RegIdxWidth-1:0] writeAddr_MEM,
    input  logic                   dmemReq_MEM,
    input  logic                   dmemReady,
    output logic                   stall_PC,
    output logic                   stall_IF_ID,
    output logic                   stall_ID_EX,
    output logic                   stall_EX_MEM,
    output logic                   bubble_ID_EX,
    output logic                   bubble_MEM_WB,
    output logic                   flush_IF_ID,
    output logic                   memFault,
    output logic [CNT_WIDTH-1:0]   stallCycles
);

    localparam int unsigned WaitWidth = $clog2(MEM_TIMEOUT) + 1;
    // The RUN cycle that detects the wait counts as the first wait cycle.
    localparam int unsigned FaultAt   = (MEM_TIMEOUT > 1) ? MEM_TIMEOUT - 2 : 0;

    ctrl_state_e          state_q, state_d;
    logic [WaitWidth-1:0] wait_cnt_q, wait_cnt_d;
    logic                 mem_fault_q;
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic                 load_use;
    logic                 data_stall;
    logic                 mem_wait;

    // A MEM-stage ALU result is always forwardable, so only loads in MEM matter.
    logic unused_regwrite_mem;
    assign unused_regwrite_mem = regWrite_MEM;

    hazard_detect u_hazard_detect (
        .readAddr1_ID  (readAddr1_ID),
        .readAddr2_ID  (readAddr2_ID),
        .useRs1_ID     (useRs1_ID),
        .useRs2_ID     (useRs2_ID),
        .branch_ID     (branch_ID),
        .regWrite_EX   (regWrite_EX),
        .memRead_EX    (memRead_EX),
        .writeAddr_EX  (writeAddr_EX),
        .memRead_MEM   (memRead_MEM),
        .writeAddr_MEM (writeAddr_MEM),
        .load_use      (load_use),
        .data_stall    (data_stall)
    );

    assign mem_wait = dmemReq_MEM && !dmemReady;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            StRun: begin
                if (mem_wait) begin
                    state_d    = StMwait;
                    wait_cnt_d = '0;
                end
            end
            StMwait: begin
                if (dmemReady) begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WaitWidth'(FaultAt)) begin
                    state_d    = StFault;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitWidth'(1);
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StFault;
            end
        endcase
    end

    always_comb begin
        stall_PC      = 1'b0;
        stall_IF_ID   = 1'b0;
        stall_ID_EX   = 1'b0;
        stall_EX_MEM  = 1'b0;
        bubble_ID_EX  = 1'b0;
        bubble_MEM_WB = 1'b0;
        flush_IF_ID   = 1'b0;
        if (!rst) begin
            if (state_q == StFault || mem_wait) begin
                // Freeze the whole front of the pipe; WB receives NOPs meanwhile.
                stall_PC      = 1'b1;
                stall_IF_ID   = 1'b1;
                stall_ID_EX   = 1'b1;
                stall_EX_MEM  = 1'b1;
                bubble_MEM_WB = 1'b1;
            end else begin
                stall_PC     = data_stall;
                stall_IF_ID  = data_stall;
                bubble_ID_EX = load_use;
                flush_IF_ID  = branch_ID && branchTaken_ID && !data_stall &&
                               (state_q == StRun);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            wait_cnt_q  <= '0;
            mem_fault_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_fault_q <= mem_fault_q | (state_d == StFault);
            if (stall_PC) begin
                stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign memFault    = mem_fault_q;
    assign stallCycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: directed pipeline scenarios then random traffic.
module tb_hazard_controller;

    localparam int unsigned MemTimeout = 16;
    localparam int unsigned CntWidth   = 8;

    typedef struct packed {
        logic                stall_pc;
        logic                stall_if_id;
        logic                stall_id_ex;
        logic                stall_ex_mem;
        logic                bubble_id_ex;
        logic                bubble_mem_wb;
        logic                flush_if_id;
        logic                mem_fault;
        logic [CntWidth-1:0] stall_cycles;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] readAddr1_ID, readAddr2_ID, writeAddr_EX, writeAddr_MEM;
    logic useRs1_ID, useRs2_ID, branch_ID, branchTaken_ID;
    logic regWrite_EX, memRead_EX, regWrite_MEM, memRead_MEM, dmemReq_MEM, dmemReady;
    logic stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM;
    logic bubble_ID_EX, bubble_MEM_WB, flush_IF_ID, memFault;
    logic [CntWidth-1:0] stallCycles;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state: sticky fault, consecutive prior wait cycles, stall count.
    bit          m_fault = 1'b0;
    int unsigned m_run   = 0;
    int unsigned m_cnt   = 0;

    always #5 clk = ~clk;

    hazard_controller #(
        .MEM_TIMEOUT (MemTimeout),
        .CNT_WIDTH   (CntWidth)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .readAddr1_ID   (readAddr1_ID),
        .readAddr2_ID   (readAddr2_ID),
        .useRs1_ID      (useRs1_ID),
        .useRs2_ID      (useRs2_ID),
        .branch_ID      (branch_ID),
        .branchTaken_ID (branchTaken_ID),
        .regWrite_EX    (regWrite_EX),
        .memRead_EX     (memRead_EX),
        .writeAddr_EX   (writeAddr_EX),
        .regWrite_MEM   (regWrite_MEM),
        .memRead_MEM    (memRead_MEM),
        .writeAddr_MEM  (writeAddr_MEM),
        .dmemReq_MEM    (dmemReq_MEM),
        .dmemReady      (dmemReady),
        .stall_PC       (stall_PC),
        .stall_IF_ID    (stall_IF_ID),
        .stall_ID_EX    (stall_ID_EX),
        .stall_EX_MEM   (stall_EX_MEM),
        .bubble_ID_EX   (bubble_ID_EX),
        .bubble_MEM_WB  (bubble_MEM_WB),
        .flush_IF_ID    (flush_IF_ID),
        .memFault       (memFault),
        .stallCycles    (stallCycles)
    );

    // True when some register the ID instruction really reads is the nonzero dst.
    function automatic bit reads_reg(input logic [4:0] dst);
        logic [4:0] srcs[$];
        if (useRs1_ID) srcs.push_back(readAddr1_ID);
        if (useRs2_ID) srcs.push_back(readAddr2_ID);
        foreach (srcs[i]) begin
            if (dst != 5'd0 && srcs[i] == dst) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic clear_inputs();
        readAddr1_ID = '0; readAddr2_ID = '0; useRs1_ID = 1'b0; useRs2_ID = 1'b0;
        branch_ID = 1'b0; branchTaken_ID = 1'b0;
        regWrite_EX = 1'b0; memRead_EX = 1'b0; writeAddr_EX = '0;
        regWrite_MEM = 1'b0; memRead_MEM = 1'b0; writeAddr_MEM = '0;
        dmemReq_MEM = 1'b0; dmemReady = 1'b0;
    endtask

    // Predict this cycle's outputs, queue them, advance the model across the next edge.
    task automatic step();
        exp_t e;
        bit waiting, lu, ds;
        e = '0;
        e.mem_fault    = m_fault;
        e.stall_cycles = CntWidth'(m_cnt);
        waiting = dmemReq_MEM && !dmemReady;
        if (!rst) begin
            if (m_fault || waiting) begin
                e.stall_pc = 1'b1; e.stall_if_id = 1'b1;
                e.stall_id_ex = 1'b1; e.stall_ex_mem = 1'b1;
                e.bubble_mem_wb = 1'b1;
            end else begin
                lu = memRead_EX && reads_reg(writeAddr_EX);
                ds = lu || (branch_ID && ((regWrite_EX && reads_reg(writeAddr_EX)) ||
                                          (memRead_MEM && reads_reg(writeAddr_MEM))));
                e.stall_pc     = ds;
                e.stall_if_id  = ds;
                e.bubble_id_ex = lu;
                e.flush_if_id  = branch_ID && branchTaken_ID && !ds && (m_run == 0);
            end
        end
        exp_q.push_back(e);
        if (rst) begin
            m_fault = 1'b0; m_run = 0; m_cnt = 0;
        end else begin
            if (e.stall_pc) m_cnt = (m_cnt + 1) % (1 << CntWidth);
            if (!m_fault) begin
                if (waiting) begin
                    m_run++;
                    if (m_run >= MemTimeout) m_fault = 1'b1;
                end else begin
                    m_run = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, bubble_ID_EX,
                 bubble_MEM_WB, flush_IF_ID, memFault, stallCycles};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got stalls=%b%b%b%b bub=%b%b flush=%b fault=%b cnt=%0d expected stalls=%b%b%b%b bub=%b%b flush=%b fault=%b cnt=%0d",
                         $time, a.stall_pc, a.stall_if_id, a.stall_id_ex, a.stall_ex_mem,
                         a.bubble_id_ex, a.bubble_mem_wb, a.flush_if_id, a.mem_fault,
                         a.stall_cycles, e.stall_pc, e.stall_if_id, e.stall_id_ex,
                         e.stall_ex_mem, e.bubble_id_ex, e.bubble_mem_wb, e.flush_if_id,
                         e.mem_fault, e.stall_cycles);
            end
        end
    end

    initial begin
        int unsigned wait_left;
        bit pend;
        int r;
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(); step();
        rst = 1'b0;
        step();

        // lw x5 in EX, add reading x5 in ID
        memRead_EX = 1; regWrite_EX = 1; writeAddr_EX = 5; readAddr1_ID = 5; useRs1_ID = 1;
        step();
        clear_inputs();
        memRead_MEM = 1; regWrite_MEM = 1; writeAddr_MEM = 5; readAddr1_ID = 5; useRs1_ID = 1;
        step();
        clear_inputs(); step();

        // lw x6 then taken beq on x6
        branch_ID = 1; branchTaken_ID = 1; readAddr1_ID = 6; useRs1_ID = 1;
        memRead_EX = 1; regWrite_EX = 1; writeAddr_EX = 6;
        step();
        memRead_EX = 0; regWrite_EX = 0; writeAddr_EX = 0;
        memRead_MEM = 1; regWrite_MEM = 1; writeAddr_MEM = 6;
        step();
        memRead_MEM = 0; regWrite_MEM = 0; writeAddr_MEM = 0;
        step();
        clear_inputs();

        // ALU result feeding a branch through rs2
        branch_ID = 1; readAddr2_ID = 7; useRs2_ID = 1; regWrite_EX = 1; writeAddr_EX = 7;
        step();
        regWrite_EX = 0; writeAddr_EX = 0; regWrite_MEM = 1; writeAddr_MEM = 7;
        step();
        clear_inputs();

        // Loads to x0 and unused source fields never stall
        memRead_EX = 1; regWrite_EX = 1; writeAddr_EX = 0; useRs1_ID = 1; useRs2_ID = 1;
        branch_ID = 1; branchTaken_ID = 1;
        step();
        clear_inputs();
        memRead_EX = 1; writeAddr_EX = 9; readAddr1_ID = 9; readAddr2_ID = 9;
        step();
        clear_inputs();

        // Three-cycle memory wait
        dmemReq_MEM = 1;
        repeat (3) step();
        dmemReady = 1; step();
        clear_inputs(); step();

        // Load-use hidden behind a memory wait, then seen once the access completes
        memRead_EX = 1; regWrite_EX = 1; writeAddr_EX = 5; readAddr1_ID = 5; useRs1_ID = 1;
        dmemReq_MEM = 1;
        repeat (2) step();
        dmemReady = 1; step();
        clear_inputs(); step();

        // Timeout into FAULT, held until reset
        dmemReq_MEM = 1;
        repeat (19) step();
        dmemReady = 1; step();
        clear_inputs(); branch_ID = 1; branchTaken_ID = 1; step();
        rst = 1; step();
        rst = 0; clear_inputs(); step();

        // Reset in the middle of a wait forgets it
        dmemReq_MEM = 1;
        repeat (5) step();
        rst = 1; step();
        rst = 0; dmemReady = 1; step();
        clear_inputs(); step();

        wait_left = 0;
        pend = 0;
        for (int n = 0; n < 800; n++) begin
            readAddr1_ID   = 5'($urandom_range(0, 3));
            readAddr2_ID   = 5'($urandom_range(0, 3));
            useRs1_ID      = 1'($urandom);
            useRs2_ID      = 1'($urandom);
            branch_ID      = ($urandom_range(0, 2) == 0);
            branchTaken_ID = 1'($urandom);
            regWrite_EX    = 1'($urandom);
            memRead_EX     = ($urandom_range(0, 2) == 0);
            writeAddr_EX   = 5'($urandom_range(0, 3));
            regWrite_MEM   = 1'($urandom);
            memRead_MEM    = ($urandom_range(0, 2) == 0);
            writeAddr_MEM  = 5'($urandom_range(0, 3));
            rst = (m_fault && $urandom_range(0, 7) == 0) || ($urandom_range(0, 99) == 0);
            if (wait_left > 0) begin
                dmemReq_MEM = 1; dmemReady = 0;
                wait_left--;
                if (wait_left == 0) pend = 1;
            end else if (pend) begin
                dmemReq_MEM = 1; dmemReady = 1; pend = 0;
            end else begin
                r = $urandom_range(0, 9);
                if (r < 5) begin
                    dmemReq_MEM = 0; dmemReady = 1'($urandom);
                end else if (r < 8) begin
                    dmemReq_MEM = 1; dmemReady = 1;
                end else begin
                    dmemReq_MEM = 1; dmemReady = 0;
                    wait_left = ($urandom_range(0, 9) == 0) ? 19 : $urandom_range(0, 4);
                    pend = (wait_left == 0);
                end
            end
            if (rst) begin
                wait_left = 0;
                pend = 0;
            end
            step();
        end
        rst = 0;
        clear_inputs();
        step(); step();

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
